mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file and consumes read_data_1/read_data_2 as rs/rt operands for MULT, MULTU, DIV and DIVU. HI/LO are exposed for MFHI/MFLO write-back into the register file's write_data path. The unit is shift-add / restoring-divide, one bit per cycle, with a start/busy/done handshake toward the control unit.

---
 rtl/mips_muldiv_pkg.sv | 18 +
 rtl/mips_abs_neg.sv | 14 +
 rtl/mips_muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared constants and types for the iterative MIPS multiply/divide unit.
package mips_muldiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = WIDTH;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mips_abs_neg.sv
// Combinational conditional two's-complement negate.
module mips_abs_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  always_comb begin
    y = neg ? (~a + 1'b1) : a;
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers,
// one bit per cycle, start/busy/done handshake.
module mips_muldiv_unit #(
  parameter int unsigned      WIDTH   = mips_muldiv_pkg::WIDTH,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_lo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_muldiv_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dzo_q, dzo_d;

  logic             is_signed;
  logic             in_fix;
  logic [WIDTH-1:0] na_in, nb_in, na_y, nb_y;
  logic             na_neg, nb_neg;
  logic [W2-1:0]    prod_y;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH+1:0] sub_trial;

  assign is_signed = ~op[0];
  assign in_fix    = (state_q == FIX);

  // The two operand negators are reused in FIX to sign-correct quotient and remainder.
  assign na_in  = in_fix ? acc_q[WIDTH-1:0] : rs_data;
  assign na_neg = in_fix ? negq_q : (is_signed & rs_data[WIDTH-1]);
  assign nb_in  = in_fix ? acc_q[W2-1:WIDTH] : rt_data;
  assign nb_neg = in_fix ? negr_q : (is_signed & rt_data[WIDTH-1]);

  mips_abs_neg #(.W(WIDTH)) u_neg_a (.a(na_in), .neg(na_neg), .y(na_y));
  mips_abs_neg #(.W(WIDTH)) u_neg_b (.a(nb_in), .neg(nb_neg), .y(nb_y));
  mips_abs_neg #(.W(W2))    u_neg_p (.a(acc_q), .neg(negq_q), .y(prod_y));

  assign add_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opb_q};
  assign sub_trial = {1'b0, acc_q[W2-1:WIDTH-1]} - {2'b00, opb_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opb_d    = opb_q;
    rs_raw_d = rs_raw_q;
    acc_d    = acc_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dzo_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = op[1];
          opb_d    = nb_y;
          rs_raw_d = rs_data;
          acc_d    = {{WIDTH{1'b0}}, na_y};
          negq_d   = is_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          negr_d   = is_signed & rs_data[WIDTH-1];
          dz_d     = op[1] & (rt_data == '0);
        end else begin
          if (hi_we) hi_d = hi_lo_wdata;
          if (lo_we) lo_d = hi_lo_wdata;
        end
      end
      RUN: begin
        if (is_div_q) begin
          // Restoring step: shifted partial remainder is WIDTH+1 bits wide.
          if (sub_trial[WIDTH+1:WIDTH] == 2'b00)
            acc_d = {sub_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[W2-2:0], 1'b0};
        end else begin
          if (acc_q[0])
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
          else
            acc_d = {1'b0, acc_q[W2-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          lo_d  = DIV0_LO;
          hi_d  = rs_raw_q;
          dzo_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = na_y;
          hi_d = nb_y;
        end else begin
          {hi_d, lo_d} = prod_y;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opb_q    <= '0;
      rs_raw_q <= '0;
      acc_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opb_q    <= opb_d;
      rs_raw_q <= rs_raw_d;
      acc_q    <= acc_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dzo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed cases plus randomized ops vs. arithmetic model.
module tb_mips_muldiv_unit;

  localparam logic [1:0] T_MULT  = 2'b00;
  localparam logic [1:0] T_MULTU = 2'b01;
  localparam logic [1:0] T_DIV   = 2'b10;
  localparam logic [1:0] T_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, hi_lo_wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mips_muldiv_unit #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .hi_lo_wdata(hi_lo_wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint      sa, sb, sq, sr, sp;
    logic [63:0] ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    edz = 1'b0;
    eh = '0;
    el = '0;
    if (o[1] && b == 32'h0) begin
      el = 32'hFFFF_FFFF; eh = a; edz = 1'b1;
    end else begin
      case (o)
        T_MULT:  begin sp = sa * sb; up = sp; {eh, el} = up; end
        T_MULTU: begin up = ua * ub; {eh, el} = up; end
        T_DIV:   begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
        default: begin el = a / b; eh = a % b; end
      endcase
    end
  endfunction

  // Launch one op and wait (bounded) for done; operand inputs are scrambled during RUN.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_t, output logic done_t,
                        output logic [31:0] h, output logic [31:0] l,
                        output logic dz, output logic busy_d);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_t = busy;
    done_t = done;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    h = hi; l = lo; dz = div_by_zero; busy_d = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; rs_data = '0; rt_data = '0; hi_lo_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'h0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h expected all zero", busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu_max;
    int lat; logic bt, dt, dz, bd; logic [31:0] h, l;
    run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bt, dt, h, l, dz, bd);
    total++;
    if (bt !== 1'b1 || dt !== 1'b0) begin
      bad++; $display("FAIL multu_busy_start: busy=%b done=%b expected busy=1 done=0", bt, dt);
    end
    total++;
    if (lat != 33) begin bad++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    total++;
    if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001 || dz !== 1'b0 || bd !== 1'b0) begin
      bad++; $display("FAIL multu_max: hi=%h lo=%h dz=%b busy=%b expected fffffffe 00000001 0 0", h, l, dz, bd);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
      bad++; $display("FAIL done_pulse: done=%b hi=%h lo=%h expected 0 fffffffe 00000001", done, hi, lo);
    end
  endtask

  task automatic test_mult_signed;
    int lat; logic bt, dt, dz, bd; logic [31:0] h, l;
    run_op(T_MULT, 32'hFFFF_FFFD, 32'd7, lat, bt, dt, h, l, dz, bd);
    total++;
    if (lat != 33 || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mult_signed: lat=%0d hi=%h lo=%h expected 33 ffffffff ffffffeb", lat, h, l);
    end
  endtask

  task automatic test_div;
    int lat; logic bt, dt, dz, bd; logic [31:0] h, l;
    run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, lat, bt, dt, h, l, dz, bd);
    total++;
    if (lat != 33 || l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF || dz !== 1'b0) begin
      bad++; $display("FAIL div_signed: lat=%0d hi=%h lo=%h dz=%b expected 33 ffffffff fffffffd 0", lat, h, l, dz);
    end
    run_op(T_DIVU, 32'd100, 32'd7, lat, bt, dt, h, l, dz, bd);
    total++;
    if (lat != 33 || l !== 32'h0000_000E || h !== 32'h0000_0002) begin
      bad++; $display("FAIL divu: lat=%0d hi=%h lo=%h expected 33 00000002 0000000e", lat, h, l);
    end
  endtask

  task automatic test_div_zero;
    int lat; logic bt, dt, dz, bd; logic [31:0] h, l;
    run_op(T_DIV, 32'h0000_1234, 32'h0, lat, bt, dt, h, l, dz, bd);
    total++;
    if (lat != 33 || l !== 32'hFFFF_FFFF || h !== 32'h0000_1234 || dz !== 1'b1) begin
      bad++; $display("FAIL div_zero: lat=%0d hi=%h lo=%h dz=%b expected 33 00001234 ffffffff 1", lat, h, l, dz);
    end
    @(posedge clk); #1;
    total++;
    if (div_by_zero !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL div_zero_pulse: dz=%b done=%b expected 0 0", div_by_zero, done);
    end
    run_op(T_DIVU, 32'hCAFE_0001, 32'h0, lat, bt, dt, h, l, dz, bd);
    total++;
    if (l !== 32'hFFFF_FFFF || h !== 32'hCAFE_0001 || dz !== 1'b1) begin
      bad++; $display("FAIL divu_zero: hi=%h lo=%h dz=%b expected cafe0001 ffffffff 1", h, l, dz);
    end
    run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bt, dt, h, l, dz, bd);
    total++;
    if (l !== 32'h8000_0000 || h !== 32'h0 || dz !== 1'b0) begin
      bad++; $display("FAIL div_overflow: hi=%h lo=%h dz=%b expected 00000000 80000000 0", h, l, dz);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic bt, dt, dz, bd; logic [31:0] h, l;
    run_op(T_MULTU, 32'd1000, 32'd1000, lat, bt, dt, h, l, dz, bd);
    // Next start is driven in the cycle where done is high.
    run_op(T_DIVU, 32'd1000, 32'd3, lat, bt, dt, h, l, dz, bd);
    total++;
    if (bt !== 1'b1 || dt !== 1'b0 || lat != 33) begin
      bad++; $display("FAIL back_to_back_accept: busy=%b done=%b lat=%0d expected 1 0 33", bt, dt, lat);
    end
    total++;
    if (l !== 32'd333 || h !== 32'd1) begin
      bad++; $display("FAIL back_to_back_result: hi=%h lo=%h expected 00000001 0000014d", h, l);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    @(negedge clk);
    op = T_MULTU; rs_data = 32'd5; rt_data = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    start = 1'b1; op = T_MULT; rs_data = 32'd77; rt_data = 32'd99; hi_we = 1'b1; hi_lo_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    n++; start = 1'b0; hi_we = 1'b0;
    total++;
    if (busy !== 1'b1 || hi === 32'hDEAD_BEEF) begin
      bad++; $display("FAIL busy_ignore_mid: busy=%b hi=%h expected busy=1 hi not deadbeef", busy, hi);
    end
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++;
    if (n != 33 || hi !== 32'h0 || lo !== 32'h1E) begin
      bad++; $display("FAIL busy_ignore_result: lat=%0d hi=%h lo=%h expected 33 00000000 0000001e", n, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    int n;
    @(negedge clk); lo_we = 1'b1; hi_lo_wdata = 32'h0000_ABCD;
    @(posedge clk); #1; lo_we = 1'b0;
    total++;
    if (lo !== 32'h0000_ABCD || hi !== 32'h0) begin
      bad++; $display("FAIL mtlo: hi=%h lo=%h expected 00000000 0000abcd", hi, lo);
    end
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; hi_lo_wdata = 32'h1234_5678;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    total++;
    if (lo !== 32'h1234_5678 || hi !== 32'h1234_5678) begin
      bad++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h expected 12345678 12345678", hi, lo);
    end
    @(negedge clk);
    op = T_MULTU; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1; hi_we = 1'b1; hi_lo_wdata = 32'h5555_AAAA;
    @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
    total++;
    if (hi !== 32'h1234_5678 || busy !== 1'b1) begin
      bad++; $display("FAIL mthi_with_start: hi=%h busy=%b expected 12345678 1", hi, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++;
    if (n != 33 || hi !== 32'h0 || lo !== 32'd12) begin
      bad++; $display("FAIL mthi_with_start_result: lat=%0d hi=%h lo=%h expected 33 0 0000000c", n, hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic bt, dt, dz, bd; logic [31:0] h, l;
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; hi_lo_wdata = 32'h0F0F_0F0F;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    op = T_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        total++; bad++; $display("FAIL reset_mid_stale_done: done=1 expected 0");
      end
    end
    run_op(T_MULTU, 32'd2, 32'd3, lat, bt, dt, h, l, dz, bd);
    total++;
    if (lat != 33 || l !== 32'd6 || h !== 32'd0) begin
      bad++; $display("FAIL after_reset_mult: lat=%0d hi=%h lo=%h expected 33 0 00000006", lat, h, l);
    end
  endtask

  task automatic test_random;
    int lat; logic bt, dt, dz, bd; logic [31:0] h, l;
    logic [1:0] o; logic [31:0] a, b, eh, el; logic edz;
    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      ref_model(o, a, b, eh, el, edz);
      run_op(o, a, b, lat, bt, dt, h, l, dz, bd);
      total++;
      if (lat != 33 || h !== eh || l !== el || dz !== edz || bd !== 1'b0) begin
        bad++;
        $display("FAIL random[%0d] op=%0d rs=%h rt=%h: lat=%0d hi=%h lo=%h dz=%b busy=%b expected 33 %h %h %b 0",
                 k, o, a, b, lat, h, l, dz, bd, eh, el, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_busy_ignore();
    test_mthi_mtlo();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
